anita4_scaler_window_ctrl: RTL

- Sequences L0/L1/L2 scaler accumulation for the SURF trigger path.
- Counts the single-cycle scaler flags (scal_o bus of the trigger processor) over programmable windows. A window ends either on a fixed mclk period or on each TURF reference pulse.
- At each window boundary it latches all counts into a shadow bank and streams them out channel by channel over a valid/ready interface to the register/readout block.

---
 rtl/anita4_scaler_window_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/anita4_scaler_window_ctrl.sv
// Windowed L0/L1/L2 scaler accumulation: per-channel saturating counters, a shadow bank latched
// at each timer or TURF-reference boundary, and a channel-serial valid/ready readout.

module anita4_scaler_lane #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 mclk_i,
    input  logic                 rst_n_i,
    input  logic                 scal_i,
    input  logic                 clr_i,
    input  logic                 latch_i,
    output logic [CNT_WIDTH-1:0] shadow_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] live;
    logic [CNT_WIDTH-1:0] live_inc;

    // The shadow captures the count including the boundary cycle's own flag.
    assign live_inc = (scal_i && (live != CNT_MAX)) ? live + CNT_WIDTH'(1) : live;

    always_ff @(posedge mclk_i) begin
        if (!rst_n_i) begin
            live     <= '0;
            shadow_o <= '0;
        end else begin
            live <= clr_i ? '0 : live_inc;
            if (latch_i)
                shadow_o <= live_inc;
        end
    end
endmodule

module anita4_scaler_window_ctrl #(
    parameter int NCHAN        = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                     mclk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic                     mode_ref_i,
    input  logic [PERIOD_WIDTH-1:0]  period_i,
    input  logic                     ref_pulse_i,
    input  logic [NCHAN-1:0]         scal_i,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic [$clog2(NCHAN)-1:0] dout_chan_o,
    output logic [CNT_WIDTH-1:0]     dout_data_o,
    output logic                     dout_last_o,
    output logic                     frame_done_o,
    output logic [15:0]              frame_cnt_o,
    output logic                     overrun_o,
    input  logic                     clr_overrun_i,
    output logic                     busy_o
);
    localparam int CHW = $clog2(NCHAN);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_READ} state_t;

    state_t                           state;
    state_t                           state_nxt;
    logic [PERIOD_WIDTH-1:0]          timer;
    logic                             ref_d;
    logic [CHW-1:0]                   rd_chan;
    logic [NCHAN-1:0][CNT_WIDTH-1:0]  shadow;

    logic run;
    logic tmr_hit;
    logic ref_edge;
    logic boundary;
    logic latch;
    logic clr_live;
    logic ovr_set;
    logic rd_accept;
    logic rd_last;

    assign run       = enable_i && (state != S_IDLE);
    assign tmr_hit   = (period_i != '0) && (timer == period_i - PERIOD_WIDTH'(1));
    assign ref_edge  = ref_pulse_i && !ref_d;
    assign rd_last   = (rd_chan == CHW'(NCHAN - 1));
    assign rd_accept = (state == S_READ) && dout_ready_i;

    always_ff @(posedge mclk_i) begin
        if (!rst_n_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        ovr_set   = 1'b0;
        clr_live  = 1'b1;
        boundary  = run && (mode_ref_i ? ref_edge : tmr_hit);
        case (state)
            S_IDLE: begin
                if (enable_i)
                    state_nxt = S_COUNT;
            end
            S_COUNT: begin
                clr_live = !enable_i || boundary;
                if (!enable_i)
                    state_nxt = S_IDLE;
                else if (boundary) begin
                    latch     = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                // A window ending mid-readout is dropped rather than corrupting the shadow bank.
                clr_live = !enable_i || boundary;
                ovr_set  = boundary;
                if (rd_accept && rd_last)
                    state_nxt = enable_i ? S_COUNT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk_i) begin
        if (!rst_n_i) begin
            timer        <= '0;
            ref_d        <= 1'b0;
            rd_chan      <= '0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
            overrun_o    <= 1'b0;
        end else begin
            ref_d        <= ref_pulse_i;
            frame_done_o <= rd_accept && rd_last;
            frame_cnt_o  <= frame_cnt_o + 16'(latch);
            if (!run || mode_ref_i || tmr_hit)
                timer <= '0;
            else
                timer <= timer + PERIOD_WIDTH'(1);
            if (rd_accept)
                rd_chan <= rd_last ? '0 : rd_chan + CHW'(1);
            if (ovr_set)
                overrun_o <= 1'b1;
            else if (clr_overrun_i)
                overrun_o <= 1'b0;
        end
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_lane
        anita4_scaler_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .mclk_i   (mclk_i),
            .rst_n_i  (rst_n_i),
            .scal_i   (scal_i[g]),
            .clr_i    (clr_live),
            .latch_i  (latch),
            .shadow_o (shadow[g])
        );
    end

    assign dout_valid_o = (state == S_READ);
    assign busy_o       = (state == S_READ);
    assign dout_chan_o  = rd_chan;
    assign dout_data_o  = shadow[rd_chan];
    assign dout_last_o  = dout_valid_o && rd_last;
endmodule
